// File: rtl/vu_level_tracker.sv
// VU meter ballistics: instant-attack/linear-decay bar, peak-hold marker (hold then fall), clip flag.
// Optional macro VU_CLIP_LATCH_EN makes clip sticky on a full-scale accepted sample until reset.
module vu_level_tracker #(
    parameter int DATA_W          = 8,
    parameter int TICK_DIV        = 250000,
    parameter int DECAY_STEP      = 4,
    parameter int PEAK_HOLD_TICKS = 100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              sample_error,
    output logic [DATA_W-1:0] level,
    output logic [DATA_W-1:0] peak,
    output logic              clip,
    output logic              tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(PEAK_HOLD_TICKS + 1);
    localparam logic [PW-1:0]     LAST      = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0]     HOLD_INIT = HW'(PEAK_HOLD_TICKS);
    localparam logic [DATA_W-1:0] STEP      = DATA_W'(DECAY_STEP);

    typedef enum logic [1:0] {IDLE, HOLD, FALL} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     presc;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic              acc;
    logic [DATA_W-1:0] s, lvl_dec, lvl_n, level_n, peak_n, pk_dec, pk_fall;

    function automatic logic [DATA_W-1:0] dec(input logic [DATA_W-1:0] x);
        return (x < STEP) ? '0 : x - STEP;
    endfunction

    always_comb begin
        acc     = enable & sample_valid & ~sample_error;
        s       = acc ? sample : '0;
        lvl_dec = tick ? dec(level) : level;
        lvl_n   = (s > lvl_dec) ? s : lvl_dec;
        pk_dec  = dec(peak);
        pk_fall = (pk_dec > lvl_n) ? pk_dec : lvl_n;
        level_n = enable ? lvl_n : level;
        state_n = state;
        peak_n  = peak;
        hold_n  = hold_cnt;
        if (enable) begin
            // A new maximum re-arms the hold from any state.
            if (acc && (sample >= peak)) begin
                peak_n  = sample;
                hold_n  = HOLD_INIT;
                state_n = HOLD;
            end else begin
                case (state)
                    IDLE: peak_n = lvl_n;
                    HOLD: if (tick) begin
                        hold_n = hold_cnt - HW'(1);
                        if (hold_cnt == HW'(1)) state_n = FALL;
                    end
                    FALL: if (tick) begin
                        peak_n = pk_fall;
                        if (pk_fall == lvl_n) state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc    <= '0;
            tick     <= 1'b0;
            level    <= '0;
            peak     <= '0;
            clip     <= 1'b0;
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            if (enable) begin
                presc <= (presc == LAST) ? '0 : presc + PW'(1);
                tick  <= (presc == LAST);
            end else begin
                tick  <= 1'b0;
            end
            level    <= level_n;
            peak     <= peak_n;
            state    <= state_n;
            hold_cnt <= hold_n;
`ifdef VU_CLIP_LATCH_EN
            clip     <= clip | (acc && (sample == {DATA_W{1'b1}}));
`else
            clip     <= (peak_n == {DATA_W{1'b1}});
`endif
        end
    end
endmodule

// File: tb/tb_vu_level_tracker.sv
// Directed bench for vu_level_tracker with TICK_DIV=4, DECAY_STEP=16, PEAK_HOLD_TICKS=3.
module tb_vu_level_tracker;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] sample = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_error = 1'b0;
    logic [7:0] level, peak;
    logic       clip, tick;

    int n_cmp = 0;
    int n_err = 0;

`ifdef VU_CLIP_LATCH_EN
    localparam logic CLIP_AFTER_FALL = 1'b1;
`else
    localparam logic CLIP_AFTER_FALL = 1'b0;
`endif

    localparam logic [7:0] EXP_L [0:10] = '{8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20,
                                            8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] EXP_P [0:10] = '{8'h80, 8'h80, 8'h80, 8'h70, 8'h60, 8'h50,
                                            8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
    localparam logic [7:0] EXP_D [0:5]  = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h00, 8'h00};

    vu_level_tracker #(.DATA_W(8), .TICK_DIV(4), .DECAY_STEP(16), .PEAK_HOLD_TICKS(3)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sample(sample),
        .sample_valid(sample_valid), .sample_error(sample_error),
        .level(level), .peak(peak), .clip(clip), .tick(tick)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            n_cmp++;
            if (peak < level) begin
                n_err++;
                $display("FAIL invariant: peak=%h < level=%h", peak, level);
            end
        end
    end

    // Returns at a negedge where tick is high; decay lands on the next posedge.
    task automatic wait_tick(input string nm);
        int k = 0;
        while (!tick && k < 12) begin
            @(negedge clock);
            k++;
        end
        if (!tick) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: tick timeout, got tick=%b need 1", nm, tick);
        end
    endtask

    task automatic settle(input string nm);
        int k = 0;
        while ((level != 8'h00 || peak != 8'h00) && k < 300) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (level !== 8'h00 || peak !== 8'h00) begin
            n_err++;
            $display("FAIL %s: settle got level=%h peak=%h need 00/00", nm, level, peak);
        end
    endtask

    task automatic accept(input logic [7:0] v);
        @(negedge clock);
        sample = v; sample_valid = 1'b1; sample_error = 1'b0;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; sample = 8'hFF; sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (level !== 8'h00 || peak !== 8'h00 || clip !== 1'b0 || tick !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: got level=%h peak=%h clip=%b tick=%b need 0", i, level, peak, clip, tick);
            end
        end
        sample_valid = 1'b0; sample = 8'h00;
        reset = 1'b1;
    endtask

    task automatic test_attack_decay;
        accept(8'h50);
        n_cmp++;
        if (level !== 8'h50) begin
            n_err++;
            $display("FAIL attack: got level=%h need 50", level);
        end
        for (int i = 0; i < 6; i++) begin
            wait_tick("decay");
            @(negedge clock);
            n_cmp++;
            if (level !== EXP_D[i]) begin
                n_err++;
                $display("FAIL decay[%0d]: got level=%h need %h", i, level, EXP_D[i]);
            end
        end
    endtask

    task automatic test_peak_hold;
        settle("peak_pre");
        accept(8'h80);
        n_cmp++;
        if (level !== 8'h80 || peak !== 8'h80) begin
            n_err++;
            $display("FAIL peak_load: got level=%h peak=%h need 80/80", level, peak);
        end
        for (int i = 0; i < 11; i++) begin
            wait_tick("peak");
            @(negedge clock);
            n_cmp++;
            if (level !== EXP_L[i] || peak !== EXP_P[i]) begin
                n_err++;
                $display("FAIL peak[%0d]: got level=%h peak=%h need %h/%h", i, level, peak, EXP_L[i], EXP_P[i]);
            end
        end
        wait_tick("peak_idle");
        @(negedge clock);
        n_cmp++;
        if (level !== 8'h00 || peak !== 8'h00) begin
            n_err++;
            $display("FAIL peak_idle: got level=%h peak=%h need 00/00", level, peak);
        end
    endtask

    task automatic test_error_drop;
        @(negedge clock);
        sample = 8'hC0; sample_valid = 1'b1; sample_error = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0; sample_error = 1'b0;
        n_cmp++;
        if (level !== 8'h00 || peak !== 8'h00) begin
            n_err++;
            $display("FAIL error_drop: got level=%h peak=%h need 00/00", level, peak);
        end
        accept(8'hC0);
        n_cmp++;
        if (level !== 8'hC0 || peak !== 8'hC0) begin
            n_err++;
            $display("FAIL error_ok: got level=%h peak=%h need C0/C0", level, peak);
        end
    endtask

    task automatic test_same_cycle;
        settle("same_pre");
        accept(8'h40);
        wait_tick("same");
        sample = 8'h35; sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        n_cmp++;
        if (level !== 8'h35 || peak !== 8'h40) begin
            n_err++;
            $display("FAIL same_cycle: got level=%h peak=%h need 35/40", level, peak);
        end
    endtask

    task automatic test_clip_enable;
        int k = 0;
        settle("clip_pre");
        accept(8'hFF);
        n_cmp++;
        if (clip !== 1'b1 || level !== 8'hFF || peak !== 8'hFF) begin
            n_err++;
            $display("FAIL clip_set: got clip=%b level=%h peak=%h need 1/FF/FF", clip, level, peak);
        end
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_cmp++;
            if (level !== 8'hFF || peak !== 8'hFF || tick !== 1'b0 || clip !== 1'b1) begin
                n_err++;
                $display("FAIL freeze[%0d]: got level=%h peak=%h tick=%b clip=%b need FF/FF/0/1", i, level, peak, tick, clip);
            end
        end
        enable = 1'b1;
        wait_tick("resume");
        @(negedge clock);
        n_cmp++;
        if (level !== 8'hEF || peak !== 8'hFF) begin
            n_err++;
            $display("FAIL resume: got level=%h peak=%h need EF/FF", level, peak);
        end
        while (peak == 8'hFF && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (peak !== 8'hEF || level !== 8'hBF || clip !== CLIP_AFTER_FALL) begin
            n_err++;
            $display("FAIL clip_fall: got peak=%h level=%h clip=%b need EF/BF/%b", peak, level, clip, CLIP_AFTER_FALL);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        n_cmp++;
        if (level !== 8'h00 || peak !== 8'h00 || clip !== 1'b0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got level=%h peak=%h clip=%b tick=%b need 0", level, peak, clip, tick);
        end
        accept(8'h20);
        n_cmp++;
        if (level !== 8'h20 || peak !== 8'h20 || clip !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: got level=%h peak=%h clip=%b need 20/20/0", level, peak, clip);
        end
    endtask

    initial begin
        test_reset;
        test_attack_decay;
        test_peak_hold;
        test_error_drop;
        test_same_cycle;
        test_clip_enable;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
